// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional baud-rate tick generator for the UART datapath
//
// Produces single-cycle enables on clk at the oversample rate, at the bit
// rate and at the bit midpoint, from a runtime-programmable {int,frac}
// sample-period divisor.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             run enable; low holds counters, accumulator and index cleared
//   resync         one-cycle restart of the tick phase (start-bit alignment)
//   div_load       capture div_int/div_frac into the shadow divisor
//   div_int        integer sample-period divisor (clk cycles)
//   div_frac       fractional sample-period divisor (1/2^FRAC_W cycles)
//   sample_tick    pulse at the oversample rate
//   baud_tick      pulse on the last sample tick of each bit
//   mid_tick       pulse on the sample tick at the bit midpoint
//   sample_idx     index of the most recent sample tick within the bit
//   div_active     divisor in use, {int,frac}, int clamped to >= 2

module uart_baud_gen #(
  parameter int OVERSAMPLE       = 16,
  parameter int DIV_W            = 16,
  parameter int FRAC_W           = 4,
  parameter int DEFAULT_DIV_INT  = 54,
  parameter int DEFAULT_DIV_FRAC = 4,
  localparam int IDX_W           = $clog2(OVERSAMPLE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    resync,
  input  logic                    div_load,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  output logic                    sample_tick,
  output logic                    baud_tick,
  output logic                    mid_tick,
  output logic [IDX_W-1:0]        sample_idx,
  output logic [DIV_W+FRAC_W-1:0] div_active
);

  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEFAULT_DIV_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_DIV_FRAC);
  localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(2);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  MID_IDX  = IDX_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [IDX_W-1:0]  nxt_idx;     // index the next sample tick will carry
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  shd_int;
  logic [FRAC_W-1:0] shd_frac;
  logic              pend;        // shadow holds a divisor not yet transferred

  logic [FRAC_W:0]   acc_sum;
  logic              carry;
  logic [DIV_W:0]    period_m1;
  logic              wrap;
  logic              clear;
  logic              xfer;

  // acc is held for the whole interval and advanced when it ends, so the
  // carry seen throughout an interval is the one computed at its start.
  assign acc_sum   = {1'b0, acc} + {1'b0, act_frac};
  assign carry     = acc_sum[FRAC_W];
  assign period_m1 = {1'b0, act_int} + {{DIV_W{1'b0}}, carry} - {{DIV_W{1'b0}}, 1'b1};
  assign wrap      = ({1'b0, cnt} == period_m1);
  assign clear     = resync || !en;
  // Transfer at a bit boundary, or straight away while the generator is idle.
  assign xfer      = pend && (baud_tick || !en);

  assign div_active = {act_int, act_frac};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      nxt_idx     <= '0;
      sample_idx  <= '0;
      sample_tick <= 1'b0;
      baud_tick   <= 1'b0;
      mid_tick    <= 1'b0;
      act_int     <= DEF_INT;
      act_frac    <= DEF_FRAC;
      shd_int     <= DEF_INT;
      shd_frac    <= DEF_FRAC;
      pend        <= 1'b0;
    end else begin
      if (clear) begin
        cnt         <= '0;
        acc         <= '0;
        nxt_idx     <= '0;
        sample_idx  <= '0;
        sample_tick <= 1'b0;
        baud_tick   <= 1'b0;
        mid_tick    <= 1'b0;
      end else begin
        sample_tick <= wrap;
        baud_tick   <= wrap && (nxt_idx == LAST_IDX);
        mid_tick    <= wrap && (nxt_idx == MID_IDX);
        if (wrap) begin
          cnt        <= '0;
          acc        <= acc_sum[FRAC_W-1:0];
          sample_idx <= nxt_idx;
          nxt_idx    <= nxt_idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // A new divisor starts its bit with a clean fractional phase.
        if (xfer) begin
          acc <= '0;
        end
      end

      if (xfer) begin
        act_int  <= (shd_int < MIN_INT) ? MIN_INT : shd_int;
        act_frac <= shd_frac;
        pend     <= 1'b0;
      end
      // A capture in the transfer cycle lands after the old shadow was used.
      if (div_load) begin
        shd_int  <= div_int;
        shd_frac <= div_frac;
        pend     <= 1'b1;
      end
    end
  end

endmodule
